// File: rtl/risxv_fetch_pkg.sv
// Shared types and helpers for the fetch aligner.
//   INST_W / HALF_W : instruction and halfword widths
//   is_rvc()        : true when a low halfword starts a 16-bit instruction
//   fetch_word_t    : one 32-bit word as delivered by the fetch FIFO
//   inst_pkt_t      : instruction bundle handed to decode
package risxv_fetch_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned HALF_W = 16;

    typedef logic [INST_W-1:0] fetch_word_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [INST_W-1:0] pc;
        logic              rvc;
    } inst_pkt_t;

    // Any encoding whose two low bits are not 2'b11 is compressed.
    function automatic logic is_rvc(input logic [HALF_W-1:0] h);
        return h[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_aligner.sv
// Fetch aligner: pops 32-bit fetch words from a combinational-read FIFO and
// splits/joins them into whole RV32IC instructions for decode.
//   i_clk, i_rstn             : clock, asynchronous active-low reset
//   i_fifo_data, i_fifo_empty : FIFO head word and empty flag
//   o_fifo_read               : pop request, FIFO advances at the next edge
//   o_inst_valid/i_inst_ready : decode handshake
//   o_inst, o_inst_pc         : instruction (RVC zero-extended) and its PC
//   o_inst_rvc                : instruction is 16-bit
//   i_flush, i_flush_pc       : redirect from the branch unit
module fetch_aligner
    import risxv_fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic [31:0]     i_fifo_data,
    input  logic            i_fifo_empty,
    output logic            o_fifo_read,
    output logic            o_inst_valid,
    input  logic            i_inst_ready,
    output logic [31:0]     o_inst,
    output logic [XLEN-1:0] o_inst_pc,
    output logic            o_inst_rvc,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_flush_pc
);

    // Leftover upper halfword of the previously popped word.
    logic              hb_valid_q, hb_valid_d;
    logic [HALF_W-1:0] hb_data_q, hb_data_d;
    // Discard the low halfword of the next word (redirect to pc[1]=1).
    logic              skip_lo_q, skip_lo_d;
    logic [XLEN-1:0]   pc_q, pc_d;

    fetch_word_t word;
    logic        valid;
    logic        pop;
    logic        hs;

    assign word = i_fifo_data;

    always_comb begin
        valid      = 1'b0;
        pop        = 1'b0;
        o_inst     = '0;
        o_inst_rvc = 1'b0;
        hb_valid_d = hb_valid_q;
        hb_data_d  = hb_data_q;
        skip_lo_d  = skip_lo_q;
        pc_d       = pc_q;
        hs         = 1'b0;

        if (hb_valid_q) begin
            if (is_rvc(hb_data_q)) begin
                // Buffered RVC needs nothing from the FIFO.
                valid      = 1'b1;
                o_inst     = {16'h0000, hb_data_q};
                o_inst_rvc = 1'b1;
                hs         = i_inst_ready;
                if (hs) begin
                    hb_valid_d = 1'b0;
                    pc_d       = pc_q + XLEN'(2);
                end
            end else begin
                // Straddling 32-bit: low half buffered, high half in FIFO head.
                valid  = !i_fifo_empty;
                o_inst = {word[15:0], hb_data_q};
                hs     = valid && i_inst_ready;
                if (hs) begin
                    pop       = 1'b1;
                    hb_data_d = word[31:16];
                    pc_d      = pc_q + XLEN'(4);
                end
            end
        end else if (!i_fifo_empty) begin
            if (skip_lo_q) begin
                pop        = 1'b1;
                hb_data_d  = word[31:16];
                hb_valid_d = 1'b1;
                skip_lo_d  = 1'b0;
            end else if (is_rvc(word[15:0])) begin
                valid      = 1'b1;
                o_inst     = {16'h0000, word[15:0]};
                o_inst_rvc = 1'b1;
                hs         = i_inst_ready;
                if (hs) begin
                    pop        = 1'b1;
                    hb_data_d  = word[31:16];
                    hb_valid_d = 1'b1;
                    pc_d       = pc_q + XLEN'(2);
                end
            end else begin
                valid  = 1'b1;
                o_inst = word;
                hs     = i_inst_ready;
                if (hs) begin
                    pop  = 1'b1;
                    pc_d = pc_q + XLEN'(4);
                end
            end
        end

        // Redirect overrides whatever the case logic decided.
        if (i_flush) begin
            valid      = 1'b0;
            pop        = 1'b0;
            hb_valid_d = 1'b0;
            pc_d       = i_flush_pc;
            skip_lo_d  = i_flush_pc[1];
        end
    end

    // While reset is held nothing is offered or popped, even if the FIFO has data.
    assign o_inst_valid = valid && i_rstn;
    assign o_fifo_read  = pop && i_rstn;
    assign o_inst_pc    = pc_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            hb_valid_q <= 1'b0;
            hb_data_q  <= '0;
            skip_lo_q  <= RESET_PC[1];
            pc_q       <= RESET_PC;
        end else begin
            hb_valid_q <= hb_valid_d;
            hb_data_q  <= hb_data_d;
            skip_lo_q  <= skip_lo_d;
            pc_q       <= pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
// Self-checking bench for fetch_aligner: directed vector table followed by
// randomized traffic compared against a halfword-stream reference model.
module tb_fetch_aligner;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk;
    logic        rstn;
    logic [31:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_read;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_rvc;
    logic        flush;
    logic [31:0] flush_pc;

    fetch_aligner #(
        .XLEN    (32),
        .RESET_PC(RST_PC)
    ) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_fifo_data (fifo_data),
        .i_fifo_empty(fifo_empty),
        .o_fifo_read (fifo_read),
        .o_inst_valid(inst_valid),
        .i_inst_ready(inst_ready),
        .o_inst      (inst),
        .o_inst_pc   (inst_pc),
        .o_inst_rvc  (inst_rvc),
        .i_flush     (flush),
        .i_flush_pc  (flush_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] fifo_q[$];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic upd_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 32'h0 : fifo_q[0];
    endtask

    typedef struct {
        bit          push;
        logic [31:0] word;
        bit          ready;
        bit          fl;
        logic [31:0] fpc;
        bit          ev;
        logic [31:0] einst;
        logic [31:0] epc;
        bit          ervc;
        bit          erd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit push, input logic [31:0] word, input bit ready, input bit fl,
                       input logic [31:0] fpc, input bit ev, input logic [31:0] einst,
                       input logic [31:0] epc, input bit ervc, input bit erd);
        vec_t v;
        v.push = push; v.word = word; v.ready = ready; v.fl = fl; v.fpc = fpc;
        v.ev = ev; v.einst = einst; v.epc = epc; v.ervc = ervc; v.erd = erd;
        vecs.push_back(v);
    endtask

    // Called at posedge+1; leaves the bench at the following posedge+1.
    task automatic run_row(input int idx, input vec_t v);
        logic rd;
        logic fl;
        string nm;
        if (v.push) fifo_q.push_back(v.word);
        inst_ready = v.ready;
        flush      = v.fl;
        flush_pc   = v.fpc;
        upd_fifo();
        @(negedge clk);
        nm = $sformatf("row%0d", idx);
        chk({nm, "_valid"}, 96'(inst_valid), 96'(v.ev));
        chk({nm, "_read"}, 96'(fifo_read), 96'(v.erd));
        chk({nm, "_pc"}, 96'(inst_pc), 96'(v.epc));
        if (v.ev || idx == 0) begin
            chk({nm, "_inst"}, 96'(inst), 96'(v.einst));
            chk({nm, "_rvc"}, 96'(inst_rvc), 96'(v.ervc));
        end
        rd = fifo_read;
        fl = flush;
        @(posedge clk);
        if (fl) fifo_q.delete();
        else if (rd) void'(fifo_q.pop_front());
        #1;
        flush = 1'b0;
        upd_fifo();
    endtask

    function automatic logic is16(input logic [15:0] h);
        return h[1:0] != 2'b11;
    endfunction

    function automatic logic [15:0] rand_half();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
        else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
        return h;
    endfunction

    // Reference model: the instruction stream as a flat list of halfwords
    // fetched since the last redirect, consumed from index m_idx.
    logic [15:0] m_h[$];
    int          m_idx;
    logic [31:0] m_pc;

    initial begin
        logic        mv, mrvc, rd, hs, fl;
        logic [31:0] minst, fpc;
        int          avail, stall;

        rstn = 1'b0; inst_ready = 1'b1; flush = 1'b0; flush_pc = '0;
        upd_fifo();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        //   push word           rdy fl fpc            ev inst           pc             rvc rd
        add(0, 32'h0,            1, 0, 32'h0,          0, 32'h0,         32'h8000_0000, 0, 0);
        add(1, 32'h0000_0013,    1, 0, 32'h0,          1, 32'h0000_0013, 32'h8000_0000, 0, 1);
        add(1, 32'h0010_0093,    1, 0, 32'h0,          1, 32'h0010_0093, 32'h8000_0004, 0, 1);
        add(1, 32'h4501_4501,    1, 0, 32'h0,          1, 32'h0000_4501, 32'h8000_0008, 1, 1);
        add(0, 32'h0,            1, 0, 32'h0,          1, 32'h0000_4501, 32'h8000_000A, 1, 0);
        add(1, 32'h0013_4501,    1, 0, 32'h0,          1, 32'h0000_4501, 32'h8000_000C, 1, 1);
        add(0, 32'h0,            1, 0, 32'h0,          0, 32'h0,         32'h8000_000E, 0, 0);
        add(1, 32'h1234_0000,    1, 0, 32'h0,          1, 32'h0000_0013, 32'h8000_000E, 0, 1);
        add(0, 32'h0,            1, 0, 32'h0,          1, 32'h0000_1234, 32'h8000_0012, 1, 0);
        add(1, 32'h0093_4501,    1, 0, 32'h0,          1, 32'h0000_4501, 32'h8000_0014, 1, 1);
        add(1, 32'h5678_0000,    0, 0, 32'h0,          1, 32'h0000_0093, 32'h8000_0016, 0, 0);
        add(0, 32'h0,            0, 0, 32'h0,          1, 32'h0000_0093, 32'h8000_0016, 0, 0);
        add(0, 32'h0,            0, 0, 32'h0,          1, 32'h0000_0093, 32'h8000_0016, 0, 0);
        add(0, 32'h0,            1, 0, 32'h0,          1, 32'h0000_0093, 32'h8000_0016, 0, 1);
        add(0, 32'h0,            0, 1, 32'h8000_0102,  0, 32'h0,         32'h8000_001A, 0, 0);
        add(1, 32'hABCD_0001,    1, 0, 32'h0,          0, 32'h0,         32'h8000_0102, 0, 1);
        add(0, 32'h0,            1, 0, 32'h0,          1, 32'h0000_ABCD, 32'h8000_0102, 1, 0);
        add(1, 32'h0001_4501,    1, 0, 32'h0,          1, 32'h0000_4501, 32'h8000_0104, 1, 1);
        add(0, 32'h0,            1, 0, 32'h0,          1, 32'h0000_0001, 32'h8000_0106, 1, 0);
        add(0, 32'h0,            1, 0, 32'h0,          0, 32'h0,         32'h8000_0108, 0, 0);
        add(0, 32'h0,            1, 0, 32'h0,          0, 32'h0,         32'h8000_0108, 0, 0);
        add(1, 32'h0000_0013,    1, 0, 32'h0,          1, 32'h0000_0013, 32'h8000_0108, 0, 1);
        add(0, 32'h0,            1, 1, 32'h8000_0202,  0, 32'h0,         32'h8000_010C, 0, 0);
        add(1, 32'hABCF_0001,    1, 0, 32'h0,          0, 32'h0,         32'h8000_0202, 0, 1);
        add(0, 32'h0,            1, 0, 32'h0,          0, 32'h0,         32'h8000_0202, 0, 0);
        add(1, 32'h0000_0011,    1, 0, 32'h0,          1, 32'h0011_ABCF, 32'h8000_0202, 0, 1);
        add(0, 32'h0,            1, 0, 32'h0,          1, 32'h0000_0000, 32'h8000_0206, 1, 0);
        add(0, 32'h0,            1, 1, 32'hFFFF_FFFC,  0, 32'h0,         32'h8000_0208, 0, 0);
        add(1, 32'h0000_0013,    1, 0, 32'h0,          1, 32'h0000_0013, 32'hFFFF_FFFC, 0, 1);
        add(0, 32'h0,            1, 0, 32'h0,          0, 32'h0,         32'h0000_0000, 0, 0);

        for (int i = 0; i < vecs.size(); i++) run_row(i, vecs[i]);

        // Reset asserted mid-stream with a word waiting in the FIFO.
        fifo_q.push_back(32'h0000_0013);
        upd_fifo();
        inst_ready = 1'b1;
        rstn = 1'b0;
        #2;
        chk("rst_mid_read", 96'(fifo_read), 96'(0));
        chk("rst_mid_valid", 96'(inst_valid), 96'(0));
        chk("rst_mid_pc", 96'(inst_pc), 96'(RST_PC));
        @(posedge clk);
        #1;
        fifo_q.delete();
        upd_fifo();
        rstn = 1'b1;

        // Randomized traffic.
        m_h.delete();
        m_pc  = RST_PC;
        m_idx = int'(RST_PC[1]);
        stall = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            avail = m_h.size() - m_idx;
            mv = 1'b0; mrvc = 1'b0; minst = '0;
            if (avail >= 1 && is16(m_h[m_idx])) begin
                mv = 1'b1; mrvc = 1'b1; minst = {16'h0, m_h[m_idx]};
            end else if (avail >= 2) begin
                mv = 1'b1; minst = {m_h[m_idx+1], m_h[m_idx]};
            end
            if (fifo_read) chk("rand_pop_nonempty", 96'(fifo_empty), 96'(0));
            if (flush) begin
                chk("rand_flush_quiet", 96'({inst_valid, fifo_read}), 96'(0));
                stall = 0;
            end else if (inst_valid) begin
                chk("rand_inst", {30'h0, inst_valid, inst, inst_pc, inst_rvc},
                    {30'h0, mv, minst, m_pc, mrvc});
                stall = 0;
            end else if (mv) begin
                stall++;
                if (stall > 1) chk("rand_stall", 96'(stall), 96'(1));
            end else begin
                stall = 0;
            end
            hs = inst_valid && inst_ready;
            rd = fifo_read;
            fl = flush;
            fpc = flush_pc;
            @(posedge clk);
            if (fl) begin
                fifo_q.delete();
                m_h.delete();
                m_pc  = fpc;
                m_idx = int'(fpc[1]);
            end else begin
                if (rd) void'(fifo_q.pop_front());
                if (hs) begin
                    m_idx += mrvc ? 1 : 2;
                    m_pc  += mrvc ? 32'd2 : 32'd4;
                end
                while (m_idx > 0 && m_h.size() > 0) begin
                    void'(m_h.pop_front());
                    m_idx--;
                end
            end
            #1;
            inst_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 39) == 0);
            flush_pc   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                     : 32'($urandom);
            flush_pc[0] = 1'b0;
            if (!flush && fifo_q.size() < 4 && $urandom_range(0, 1) == 1) begin
                logic [15:0] lo, hi;
                lo = rand_half();
                hi = rand_half();
                fifo_q.push_back({hi, lo});
                m_h.push_back(lo);
                m_h.push_back(hi);
            end
            upd_fifo();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
